dtrig_checker: RTL and testbench

Synthesizable pattern source and response checker for a registered WIDTH-bit data path such as the 4-bit D flip-flop stage. It drives a known vector sequence into the path's `d` input and compares the path's `q` output against the expected value delayed by LATENCY cycles. It reports a mismatch count, the first failing vector index, and a pass/done status. It sits beside the path under test in on-chip self-test builds, replacing the stimulus and inspection role of a simulation bench.

---
 rtl/dtrig_chk_pkg.sv | 31 +++
 rtl/dtrig_chk_pattern.sv | 52 +++++
 rtl/dtrig_checker.sv | 158 +++++++++++++++
 tb/tb_dtrig_checker.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/dtrig_chk_pkg.sv
// dtrig_chk_pkg: definitions shared by the dtrig_checker files.
//   - state_t: run-control FSM states
//   - ERR_W / ERR_SAT: mismatch counter width and saturation value
//   - lfsr_taps(): Fibonacci LFSR tap masks for WIDTH 4..8, used only when
//     DTRIG_CHK_LFSR_EN is defined
package dtrig_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int          ERR_W   = 8;
    localparam logic [7:0]  ERR_SAT = 8'd255;

    // The tap mask for each width gives a maximal-length sequence for a
    // left-shifting register whose new LSB is the XOR of the masked bits.
    function automatic logic [7:0] lfsr_taps(input int w);
        case (w)
            4:       lfsr_taps = 8'b0000_1100;  // bits 3,2
            5:       lfsr_taps = 8'b0001_0100;  // bits 4,2
            6:       lfsr_taps = 8'b0011_0000;  // bits 5,4
            7:       lfsr_taps = 8'b0110_0000;  // bits 6,5
            8:       lfsr_taps = 8'b1011_1000;  // bits 7,5,4,3
            default: lfsr_taps = 8'b0000_0000;
        endcase
    endfunction

endpackage

// File: rtl/dtrig_chk_pattern.sv
// dtrig_chk_pattern: stimulus vector generator for dtrig_checker.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_load         : restart the sequence (next vector is the seed, 1)
//   i_adv          : step the sequence by one vector
//   o_nxt          : vector that the caller registers on this edge
// Build option DTRIG_CHK_LFSR_EN selects a Fibonacci LFSR (WIDTH 4..8);
// otherwise the generator is a wrapping incrementer.
module dtrig_chk_pattern
    import dtrig_chk_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic             i_adv,
    output logic [WIDTH-1:0] o_nxt
);

    localparam logic [WIDTH-1:0] SEED = WIDTH'(1);

    logic [WIDTH-1:0] r_val;
    logic [WIDTH-1:0] w_step;

`ifdef DTRIG_CHK_LFSR_EN
    generate
        if (WIDTH < 4 || WIDTH > 8) begin : g_bad_width
            $error("dtrig_chk_pattern: LFSR supports WIDTH 4 to 8");
        end
    endgenerate

    localparam logic [7:0]       TAPS8 = lfsr_taps(WIDTH);
    localparam logic [WIDTH-1:0] TAPS  = TAPS8[WIDTH-1:0];

    assign w_step = {r_val[WIDTH-2:0], ^(r_val & TAPS)};
`else
    assign w_step = r_val + WIDTH'(1);
`endif

    // Seed is presented on the load edge itself so the first vector is
    // available in the first DRIVE cycle.
    assign o_nxt = i_load ? SEED : w_step;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_val <= '0;
        end else if (i_load || i_adv) begin
            r_val <= o_nxt;
        end
    end

endmodule

// File: rtl/dtrig_checker.sv
// dtrig_checker: pattern source and response checker for a registered
// WIDTH-bit path with LATENCY register stages between o_d_out and i_q_in.
//   i_clk, i_rst_n     : clock, async active-low reset
//   i_start            : run request, honoured in IDLE and DONE only
//   i_q_in             : output of the path under test
//   o_d_out            : stimulus to the path under test
//   o_busy / o_done    : run in progress / run finished
//   o_pass             : o_done with zero mismatches (combinational)
//   o_err_cnt          : saturating mismatch count
//   o_first_err_idx/_vld : index of the first mismatching vector
// Build option DTRIG_CHK_LFSR_EN switches the pattern to an LFSR sequence.
module dtrig_checker
    import dtrig_chk_pkg::*;
#(
    parameter  int WIDTH       = 4,
    parameter  int LATENCY     = 1,
    parameter  int NUM_VECTORS = 16,
    localparam int IDX_W       = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_q_in,
    output logic [WIDTH-1:0] o_d_out,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_pass,
    output logic [ERR_W-1:0] o_err_cnt,
    output logic [IDX_W-1:0] o_first_err_idx,
    output logic             o_first_err_vld
);

    generate
        if (LATENCY < 1 || LATENCY > 8) begin : g_bad_latency
            $error("dtrig_checker: LATENCY must be 1 to 8");
        end
        if (NUM_VECTORS < 1) begin : g_bad_nvec
            $error("dtrig_checker: NUM_VECTORS must be at least 1");
        end
    endgenerate

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_VECTORS - 1);
    localparam logic [3:0]       LAST_FLSH = 4'(LATENCY - 1);

    state_t           r_state, w_state_nxt;
    logic [IDX_W-1:0] r_idx;
    logic [3:0]       r_fcnt;
    logic [WIDTH-1:0] r_d_out;
    logic             r_busy, r_done;
    logic [ERR_W-1:0] r_err_cnt;
    logic [IDX_W-1:0] r_first_idx;
    logic             r_first_vld;

    // Expect pipeline {valid, value, index}; stage LATENCY-1 is the tail.
    logic [LATENCY-1:0]            r_pv;
    logic [LATENCY-1:0][WIDTH-1:0] r_pval;
    logic [LATENCY-1:0][IDX_W-1:0] r_pidx;

    logic             w_enter, w_stay, w_last_drv, w_flush_end, w_mis, w_drv;
    logic [WIDTH-1:0] w_pat_nxt;

    assign w_drv       = (r_state == ST_DRIVE);
    assign w_enter     = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && i_start;
    assign w_last_drv  = w_drv && (r_idx == LAST_IDX);
    assign w_stay      = w_drv && !w_last_drv;
    assign w_flush_end = (r_state == ST_FLUSH) && (r_fcnt == LAST_FLSH);
    assign w_mis       = r_pv[LATENCY-1] && (i_q_in != r_pval[LATENCY-1]);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (i_start)     w_state_nxt = ST_DRIVE;
            ST_DRIVE: if (w_last_drv)  w_state_nxt = ST_FLUSH;
            ST_FLUSH: if (w_flush_end) w_state_nxt = ST_DONE;
            ST_DONE:  if (i_start)     w_state_nxt = ST_DRIVE;
            default:                   w_state_nxt = ST_IDLE;
        endcase
    end

    dtrig_chk_pattern #(.WIDTH(WIDTH)) u_pattern (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_load  (w_enter),
        .i_adv   (w_stay),
        .o_nxt   (w_pat_nxt)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_fcnt  <= '0;
            r_d_out <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt == ST_DRIVE) || (w_state_nxt == ST_FLUSH);
            r_done  <= (w_state_nxt == ST_DONE);
            r_d_out <= (w_enter || w_stay) ? w_pat_nxt : '0;

            if (w_enter)     r_idx <= '0;
            else if (w_stay) r_idx <= r_idx + IDX_W'(1);

            if (w_last_drv)                  r_fcnt <= '0;
            else if (r_state == ST_FLUSH)    r_fcnt <= r_fcnt + 4'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pv   <= '0;
            r_pval <= '0;
            r_pidx <= '0;
        end else if (w_enter) begin
            r_pv   <= '0;
            r_pval <= '0;
            r_pidx <= '0;
        end else begin
            // r_d_out/r_idx describe the vector on the wire this cycle.
            r_pv[0]   <= w_drv;
            r_pval[0] <= w_drv ? r_d_out : '0;
            r_pidx[0] <= w_drv ? r_idx   : '0;
            for (int k = 1; k < LATENCY; k++) begin
                r_pv[k]   <= r_pv[k-1];
                r_pval[k] <= r_pval[k-1];
                r_pidx[k] <= r_pidx[k-1];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_err_cnt   <= '0;
            r_first_idx <= '0;
            r_first_vld <= 1'b0;
        end else if (w_enter) begin
            r_err_cnt   <= '0;
            r_first_idx <= '0;
            r_first_vld <= 1'b0;
        end else if (w_mis) begin
            if (r_err_cnt != ERR_SAT) r_err_cnt <= r_err_cnt + ERR_W'(1);
            if (!r_first_vld) begin
                r_first_idx <= r_pidx[LATENCY-1];
                r_first_vld <= 1'b1;
            end
        end
    end

    assign o_d_out         = r_d_out;
    assign o_busy          = r_busy;
    assign o_done          = r_done;
    assign o_pass          = r_done && (r_err_cnt == '0);
    assign o_err_cnt       = r_err_cnt;
    assign o_first_err_idx = r_first_idx;
    assign o_first_err_vld = r_first_vld;

endmodule

// File: tb/tb_dtrig_checker.sv
// Bench for dtrig_checker: stimulus pushes expected vectors and run results
// into queues; a monitor pops and compares as the DUT presents them.
module tb_dtrig_checker;

    localparam int W  = 4;
    localparam int L  = 1;
    localparam int N  = 16;
    localparam int W2 = 5;
    localparam int L2 = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] q_in;
    logic [W-1:0] d_out;
    logic         busy, done, pass, fvld;
    logic [7:0]   err;
    logic [3:0]   fidx;
    logic         stuck = 1'b0;

    logic          start2 = 1'b0;
    logic [W2-1:0] q2, d2;
    logic          busy2, done2, pass2, fvld2;
    logic [7:0]    err2;
    logic [3:0]    fidx2;

    always #5 clk = ~clk;

    // 1-stage paths under test; bit 0 of the first can be forced low.
    always @(posedge clk) q_in <= stuck ? (d_out & 4'b1110) : d_out;
    always @(posedge clk) q2   <= d2;

    dtrig_checker #(.WIDTH(W), .LATENCY(L), .NUM_VECTORS(N)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_q_in(q_in),
        .o_d_out(d_out), .o_busy(busy), .o_done(done), .o_pass(pass),
        .o_err_cnt(err), .o_first_err_idx(fidx), .o_first_err_vld(fvld)
    );

    // Deliberately one stage too deep for its 1-stage path.
    dtrig_checker #(.WIDTH(W2), .LATENCY(L2), .NUM_VECTORS(N)) dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start2), .i_q_in(q2),
        .o_d_out(d2), .o_busy(busy2), .o_done(done2), .o_pass(pass2),
        .o_err_cnt(err2), .o_first_err_idx(fidx2), .o_first_err_vld(fvld2)
    );

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Hand-derived vector sequences.
    function automatic logic [W-1:0] exp_vec(input int i);
`ifdef DTRIG_CHK_LFSR_EN
        logic [3:0] tbl [16] = '{4'd1, 4'd2, 4'd4, 4'd9, 4'd3, 4'd6, 4'd13, 4'd10,
                                 4'd5, 4'd11, 4'd7, 4'd15, 4'd14, 4'd12, 4'd8, 4'd1};
        exp_vec = tbl[i];
`else
        exp_vec = W'(i + 1);
`endif
    endfunction

    typedef struct {
        int err;
        int fidx;
        bit fvld;
        bit pass;
        int done_cyc;
    } res_t;

    res_t       q_res[$];
    logic [W-1:0] q_vec[$];

    // Issue a start pulse; optionally queue the expected outcome.
    task automatic run_start(input bit fault, input bit expect_it);
        res_t r;
        @(posedge clk);
        #1;
        stuck = fault;
        if (expect_it) begin
            r.err = 0; r.fidx = 0; r.fvld = 0;
            for (int i = 0; i < N; i++) begin
                q_vec.push_back(exp_vec(i));
                if (fault && exp_vec(i)[0]) begin
                    if (!r.fvld) begin r.fidx = i; r.fvld = 1; end
                    r.err++;
                end
            end
            r.pass = (r.err == 0);
            r.done_cyc = cyc + 1 + N + L;
            q_res.push_back(r);
        end
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (done) return;
        end
        check({name, "_timeout"}, 0, 1);
    endtask

    // Monitor: vector stream during the first N busy cycles, zeros during
    // flush, run results on each rising edge of done.
    bit prev_busy = 0, prev_done = 0;
    int bcnt = 0;
    always @(negedge clk) begin
        if (busy && !prev_busy) bcnt = 0;
        if (busy) begin
            if (bcnt < N) begin
                if (q_vec.size() > 0) check($sformatf("d_out_v%0d", bcnt), d_out, q_vec.pop_front());
            end else begin
                check("d_out_flush", d_out, 0);
            end
            bcnt++;
        end
        if (done && !prev_done) begin
            if (q_res.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                res_t r;
                r = q_res.pop_front();
                check("err_cnt", err, r.err);
                check("first_err_idx", fidx, r.fidx);
                check("first_err_vld", fvld, r.fvld);
                check("pass", pass, r.pass);
                check("done_cycle", cyc, r.done_cyc);
            end
        end
        prev_busy = busy;
        prev_done = done;
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_d_out", d_out, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_err", err, 0);
        check("rst_fidx", fidx, 0);
        check("rst_fvld", fvld, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // clean run
        run_start(0, 1);
        wait_done("clean");

        // start during DRIVE is ignored; done timing checked by monitor
        run_start(0, 1);
        repeat (3) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done("ignored_start");

        // stuck bit 0, then back-to-back clean run from DONE
        run_start(1, 1);
        wait_done("stuck");
        run_start(0, 1);
        check("b2b_busy", busy, 1);
        check("b2b_err_clr", err, 0);
        check("b2b_fvld_clr", fvld, 0);
        wait_done("b2b");

        // reset in DRIVE cycle 5 aborts the run
        run_start(0, 0);
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_d_out", d_out, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_err", err, 0);
        check("abort_fvld", fvld, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_stays_idle", busy, 0);
        run_start(0, 1);
        wait_done("after_abort");

        // LATENCY mismatch: every vector compared against its successor;
        // the last (16 in 5 bits) is compared against flush zeros.
        @(posedge clk);
        #1 start2 = 1'b1;
        @(posedge clk);
        #1 start2 = 1'b0;
        begin
            bit seen = 0;
            for (int k = 0; k < 200 && !seen; k++) begin
                @(negedge clk);
                if (done2) seen = 1;
            end
            check("lat2_done_seen", seen, 1);
        end
        check("lat2_err", err2, 16);
        check("lat2_fidx", fidx2, 0);
        check("lat2_fvld", fvld2, 1);
        check("lat2_pass", pass2, 0);

        repeat (3) @(negedge clk);
        check("res_queue_drained", q_res.size(), 0);
        check("vec_queue_drained", q_vec.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
